// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub arbiter: FSM states and operation codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub.sv
// Combinational signed add/sub with overflow flag.
module addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             ov
);

    logic [WIDTH:0] ext;

    // One extra sign bit gives the exact result; overflow shows up as the two
    // top bits disagreeing. This also handles subtracting the most negative
    // value, whose negation is not representable in WIDTH bits.
    always_comb begin
        if (op == OP_SUB) ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        else              ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        sum = ext[WIDTH-1:0];
        ov  = ext[WIDTH] ^ ext[WIDTH-1];
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub unit between NREQ requesters.
// Each operation: IDLE (grant + latch) -> EXEC (register result, done) -> DONE.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ-1:0]       op_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  ov
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            op_q;
    logic [PW-1:0]   pick;
    logic [WIDTH-1:0] sum;
    logic            sum_ov;

    // First requester with req set, scanning rr_ptr, rr_ptr+1, ... with wrap.
    // Descending offset order so the smallest offset is assigned last and wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] sel;
        int            idx;
        sel = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (r[idx]) sel = PW'(idx);
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] w);
        return NREQ'(1) << w;
    endfunction

    // Winner among the currently requesting blocks.
    always_comb begin
        pick = rr_pick(req, rr_ptr);
    end

    addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .sum (sum),
        .ov  (sum_ov)
    );

    // Control FSM with registered grant, done, result and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            ov     <= 1'b0;
            rr_ptr <= '0;
            win    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        win   <= pick;
                        a_q   <= a_in[pick*WIDTH +: WIDTH];
                        b_q   <= b_in[pick*WIDTH +: WIDTH];
                        op_q  <= op_in[pick];
                        gnt   <= onehot(pick);
                        state <= EXEC;
                    end else begin
                        gnt <= '0;
                    end
                end
                EXEC: begin
                    gnt    <= '0;
                    result <= sum;
                    ov     <= sum_ov;
                    done   <= onehot(win);
                    state  <= DONE;
                end
                DONE: begin
                    done   <= '0;
                    rr_ptr <= PW'((int'(win) + 1) % NREQ);
                    state  <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (WIDTH=4, NREQ=2).
module tb_addsub_arbiter;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   op_in = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           ov;

    int n_vec = 0;
    int n_bad = 0;

    addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .op_in  (op_in),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .ov     (ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        op_in[i]       = op;
        req[i]         = 1'b1;
    endtask

    // Issue one operation from requester i and check grant, latency and result.
    task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] exp_r, input logic exp_ov,
                          input string tag);
        int           g_cyc;
        int           d_cyc;
        logic [N-1:0] g;
        logic [N-1:0] d;
        g_cyc = -1;
        d_cyc = -1;
        g = '0;
        d = '0;
        set_op(i, a, b, op);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != 0 && g_cyc < 0) begin
                g_cyc = c;
                g = gnt;
            end
            if (done != 0) begin
                d_cyc = c;
                d = done;
                break;
            end
        end
        chk({tag, ".gnt"}, 32'(g), 32'(1 << i));
        chk({tag, ".gnt_at"}, 32'(g_cyc), 32'd0);
        chk({tag, ".lat"}, 32'(d_cyc - g_cyc), 32'd1);
        chk({tag, ".done"}, 32'(d), 32'(1 << i));
        chk({tag, ".res"}, 32'(result), 32'(exp_r));
        chk({tag, ".ov"}, 32'(ov), 32'(exp_ov));
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int           nd;
        int           last;
        int           sa;
        int           sb;
        int           r;
        int           seen;
        logic [W-1:0] er;
        logic [N-1:0] exp_d;

        // Reset state
        #2;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.res", 32'(result), 32'd0);
        chk("rst.ov", 32'(ov), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester directed cases
        run_op(0, 4'd3, 4'd2, 1'b0, 4'd5, 1'b0, "t1");
        run_op(1, 4'd7, 4'd1, 1'b0, 4'h8, 1'b1, "t2a");
        run_op(1, 4'h8, 4'd1, 1'b1, 4'd7, 1'b1, "t2b");
        run_op(0, 4'h8, 4'd0, 1'b1, 4'h8, 1'b0, "neg8_0");
        run_op(0, 4'd0, 4'h8, 1'b1, 4'h8, 1'b1, "0_neg8");

        // Both requesting continuously from reset: alternate 0,1,... every 3 cycles
        rst_n = 1'b0;
        @(negedge clk);
        set_op(0, 4'd1, 4'd1, 1'b0);
        set_op(1, 4'd2, 4'd3, 1'b1);
        rst_n = 1'b1;
        nd = 0;
        last = -1;
        for (int c = 0; c < 40 && nd < 6; c++) begin
            @(negedge clk);
            if (done != 0) begin
                exp_d = (nd % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr.order", 32'(done), 32'(exp_d));
                chk("rr.res", 32'(result), (nd % 2 == 0) ? 32'h2 : 32'hf);
                if (last >= 0) chk("rr.gap", 32'(c - last), 32'd3);
                last = c;
                nd++;
            end
        end
        chk("rr.count", 32'(nd), 32'd6);
        req = '0;
        repeat (2) @(negedge clk);

        // Operands changed and req dropped after grant
        set_op(0, 4'd3, 4'd2, 1'b0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                seen = 1;
                break;
            end
        end
        chk("late.gnt", 32'(seen), 32'd1);
        a_in[W-1:0] = 4'd7;
        req[0] = 1'b0;
        @(negedge clk);
        chk("late.done", 32'(done), 32'd1);
        chk("late.res", 32'(result), 32'd5);
        repeat (2) @(negedge clk);

        // Reset during EXEC abandons the operation
        set_op(0, 4'd6, 4'd1, 1'b0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                seen = 1;
                break;
            end
        end
        chk("rx.gnt", 32'(seen), 32'd1);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("rx.gnt0", 32'(gnt), 32'd0);
        chk("rx.done0", 32'(done), 32'd0);
        chk("rx.res0", 32'(result), 32'd0);
        chk("rx.ov0", 32'(ov), 32'd0);
        @(negedge clk);
        chk("rx.nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_op(1, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, "rx.r1");

        // Idle: nothing toggles, result holds
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle.gnt", 32'(gnt), 32'd0);
            chk("idle.done", 32'(done), 32'd0);
            chk("idle.res", 32'(result), 32'd2);
        end

        // Exhaustive sweep on requester 0 against the integer model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int o = 0; o < 2; o++) begin
                    sa = (a > 7) ? a - 16 : a;
                    sb = (b > 7) ? b - 16 : b;
                    r  = (o == 1) ? sa - sb : sa + sb;
                    er = r[W-1:0];
                    run_op(0, W'(a), W'(b), 1'(o), er, (r > 7 || r < -8), "sweep");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
